// File: rtl/safer_alert_manager.sv
// Crew alert manager: debounced four-level alert state, sticky flag latches, alarm and logger handshake.
// Optional build macro SAFER_ALERT_TIMESTAMP_EN adds a free-running cycle counter and an event_ts output.
module safer_alert_manager #(
    parameter int          PERSIST_CYC = 4,
    parameter int          HOLD_CYC    = 16,
    parameter logic [7:0]  CAUTION_TH  = 8'd64,
    parameter logic [7:0]  WARN_TH     = 8'd128,
    parameter logic [7:0]  CRIT_TH     = 8'd192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  risk_level,
    input  logic [15:0] alert_flags,
    input  logic        system_ok,
    input  logic        ack,
    output logic [1:0]  alert_state,
    output logic [3:0]  latched_crit,
    output logic [11:0] latched_warn,
    output logic        alarm,
    output logic        event_valid,
    input  logic        event_ready,
    output logic [3:0]  event_code,
    output logic        event_overflow
`ifdef SAFER_ALERT_TIMESTAMP_EN
    ,
    output logic [15:0] event_ts
`endif
);

    localparam int PW = $clog2(PERSIST_CYC + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_CAUTION  = 2'd1,
        ST_WARNING  = 2'd2,
        ST_CRITICAL = 2'd3
    } alert_t;

    alert_t         state_q;
    alert_t         state_d;
    logic [PW-1:0]  persist_q;
    logic [HW-1:0]  hold_q;
    logic           silenced_q;
    logic [3:0]     lcrit_q;
    logic [11:0]    lwarn_q;
    logic           ev_valid_q;
    logic [3:0]     ev_code_q;
    logic           ev_ovf_q;

    logic           crit_any;
    logic [1:0]     thr_level;
    logic [1:0]     raw_level;
    logic           bypass;
    logic           raw_above;
    logic           persist_hit;
    logic           escalate;
    logic           ack_eff;
    logic           deescalate;
    logic           state_change;

    assign crit_any = |alert_flags[15:12];

    // A failed upstream status forces at least WARNING even on a low score.
    always_comb begin
        thr_level = 2'd0;
        if (risk_level >= CRIT_TH)
            thr_level = 2'd3;
        else if (risk_level >= WARN_TH)
            thr_level = 2'd2;
        else if (risk_level >= CAUTION_TH)
            thr_level = 2'd1;
        raw_level = crit_any ? 2'd3 : thr_level;
        if (!system_ok && raw_level < 2'd2)
            raw_level = 2'd2;
    end

    assign bypass      = in_valid && crit_any;
    assign raw_above   = in_valid && (raw_level > state_q);
    assign persist_hit = !bypass && raw_above && (state_q != ST_CRITICAL)
                         && (persist_q == PW'(PERSIST_CYC - 1));
    assign escalate    = bypass || persist_hit;
    // Escalation owns the cycle: a coincident ack is discarded completely.
    assign ack_eff     = ack && !escalate;
    assign deescalate  = ack_eff && (hold_q == '0) && in_valid && (raw_level < state_q);

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_NORMAL;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bypass)
            state_d = ST_CRITICAL;
        else if (persist_hit)
            state_d = alert_t'(state_q + 2'd1);
        else if (deescalate)
            state_d = alert_t'(raw_level);
    end

    always_comb begin
        alert_state = state_q;
        alarm       = (state_q >= ST_WARNING) && !silenced_q;
    end

    assign state_change = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (rst)
            persist_q <= '0;
        else if (escalate)
            persist_q <= '0;
        else if (in_valid)
            persist_q <= raw_above ? persist_q + PW'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            hold_q <= '0;
        else if (escalate)
            hold_q <= HW'(HOLD_CYC);
        else if (hold_q != '0)
            hold_q <= hold_q - HW'(1);
    end

    // Ack replaces the latches with whatever is still active, or clears them if nothing is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            lcrit_q <= '0;
            lwarn_q <= '0;
        end else if (ack_eff) begin
            lcrit_q <= in_valid ? alert_flags[15:12] : 4'h0;
            lwarn_q <= in_valid ? alert_flags[11:0]  : 12'h0;
        end else if (in_valid) begin
            lcrit_q <= lcrit_q | alert_flags[15:12];
            lwarn_q <= lwarn_q | alert_flags[11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            silenced_q <= 1'b0;
        else if (escalate)
            silenced_q <= 1'b0;
        else if (ack_eff)
            silenced_q <= 1'b1;
    end

    // event_valid/event_code hold until event_valid && event_ready; a new state change
    // in the accepting cycle loads cleanly, otherwise it overwrites and flags overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            ev_valid_q <= 1'b0;
            ev_code_q  <= 4'h0;
            ev_ovf_q   <= 1'b0;
        end else if (state_change) begin
            ev_valid_q <= 1'b1;
            ev_code_q  <= {state_q, state_d};
            if (ev_valid_q && !event_ready)
                ev_ovf_q <= 1'b1;
        end else if (ev_valid_q && event_ready) begin
            ev_valid_q <= 1'b0;
        end
    end

`ifdef SAFER_ALERT_TIMESTAMP_EN
    logic [15:0] cycle_q;
    logic [15:0] ts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= 16'h0;
            ts_q    <= 16'h0;
        end else begin
            cycle_q <= cycle_q + 16'h1;
            if (state_change)
                ts_q <= cycle_q;
        end
    end

    assign event_ts = ts_q;
`endif

    assign latched_crit   = lcrit_q;
    assign latched_warn   = lwarn_q;
    assign event_valid    = ev_valid_q;
    assign event_code     = ev_code_q;
    assign event_overflow = ev_ovf_q;

endmodule

// File: tb/tb_safer_alert_manager.sv
// Bench for safer_alert_manager: directed scenarios plus random traffic against a behavioural model.
// Per-cycle expected outputs are queued by the driver and checked by an independent monitor.
module tb_safer_alert_manager;

    localparam int W = 41;
    localparam int PERSIST_CYC = 4;
    localparam int HOLD_CYC    = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  risk_level;
    logic [15:0] alert_flags;
    logic        system_ok;
    logic        ack;
    logic [1:0]  alert_state;
    logic [3:0]  latched_crit;
    logic [11:0] latched_warn;
    logic        alarm;
    logic        event_valid;
    logic        event_ready;
    logic [3:0]  event_code;
    logic        event_overflow;
`ifdef SAFER_ALERT_TIMESTAMP_EN
    logic [15:0] event_ts;
`endif

    safer_alert_manager dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .risk_level     (risk_level),
        .alert_flags    (alert_flags),
        .system_ok      (system_ok),
        .ack            (ack),
        .alert_state    (alert_state),
        .latched_crit   (latched_crit),
        .latched_warn   (latched_warn),
        .alarm          (alarm),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_code     (event_code),
        .event_overflow (event_overflow)
`ifdef SAFER_ALERT_TIMESTAMP_EN
        ,
        .event_ts       (event_ts)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // Reference model state
    int          m_state, m_persist, m_hold, m_sil;
    int          m_ev_valid, m_ev_code, m_ovf;
    int          m_cyc, m_ts;
    logic [3:0]  m_lcrit;
    logic [11:0] m_lwarn;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int level_of(input logic [7:0] rk, input logic [15:0] fl, input logic so);
        int lv;
        if (fl[15:12] != 4'h0)   lv = 3;
        else if (rk >= 8'd192)   lv = 3;
        else if (rk >= 8'd128)   lv = 2;
        else if (rk >= 8'd64)    lv = 1;
        else                     lv = 0;
        if (!so && lv < 2) lv = 2;
        return lv;
    endfunction

    task automatic model_step();
        int  raw, nst;
        bit  esc, ack_eff;
        if (rst) begin
            m_state = 0; m_persist = 0; m_hold = 0; m_sil = 0;
            m_ev_valid = 0; m_ev_code = 0; m_ovf = 0; m_cyc = 0; m_ts = 0;
            m_lcrit = 0; m_lwarn = 0;
            return;
        end
        raw = level_of(risk_level, alert_flags, system_ok);
        nst = m_state;
        esc = 0;
        if (in_valid && alert_flags[15:12] != 4'h0) begin
            nst = 3; m_persist = 0; esc = 1;
        end else if (in_valid) begin
            if (raw > m_state) begin
                m_persist++;
                if (m_persist >= PERSIST_CYC) begin
                    nst = m_state + 1; m_persist = 0; esc = 1;
                end
            end else begin
                m_persist = 0;
            end
        end
        ack_eff = ack && !esc;
        if (ack_eff && m_hold == 0 && in_valid && raw < m_state) nst = raw;
        if (esc) m_hold = HOLD_CYC;
        else if (m_hold > 0) m_hold--;
        if (ack_eff) begin
            m_lcrit = in_valid ? alert_flags[15:12] : 4'h0;
            m_lwarn = in_valid ? alert_flags[11:0] : 12'h0;
        end else if (in_valid) begin
            m_lcrit |= alert_flags[15:12];
            m_lwarn |= alert_flags[11:0];
        end
        if (esc) m_sil = 0;
        else if (ack_eff) m_sil = 1;
        if (nst != m_state) begin
            if (m_ev_valid && !event_ready) m_ovf = 1;
            m_ev_code = m_state * 4 + nst;
            m_ev_valid = 1;
            m_ts = m_cyc;
        end else if (m_ev_valid && event_ready) begin
            m_ev_valid = 0;
        end
        m_cyc = (m_cyc + 1) % 65536;
        m_state = nst;
    endtask

    function automatic logic [W-1:0] model_out();
        logic al;
        al = (m_state >= 2) && !m_sil;
        return {2'(m_state), m_lcrit, m_lwarn, al, 1'(m_ev_valid), 4'(m_ev_code), 1'(m_ovf), 16'(m_ts)};
    endfunction

    // Driver: inputs change on the falling edge; the expected post-edge outputs are queued.
    task automatic cycle(input logic r, input logic v, input logic [7:0] rk, input logic [15:0] fl,
                         input logic so, input logic a, input logic rd);
        @(negedge clk);
        rst = r; in_valid = v; risk_level = rk; alert_flags = fl;
        system_ok = so; ack = a; event_ready = rd;
        model_step();
        exp_q.push_back(model_out());
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor / scoreboard
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("alert_state",    alert_state,    e[40:39]);
                chk("latched_crit",   latched_crit,   e[38:35]);
                chk("latched_warn",   latched_warn,   e[34:23]);
                chk("alarm",          alarm,          e[22]);
                chk("event_valid",    event_valid,    e[21]);
                chk("event_code",     event_code,     e[20:17]);
                chk("event_overflow", event_overflow, e[16]);
`ifdef SAFER_ALERT_TIMESTAMP_EN
                if (e[21]) chk("event_ts", event_ts, e[15:0]);
`endif
            end
        end
    end

    initial begin
        logic [7:0] base;
        rst = 1'b1; in_valid = 1'b0; risk_level = 8'h0; alert_flags = 16'h0;
        system_ok = 1'b1; ack = 1'b0; event_ready = 1'b0;

        // Reset state
        cycle(1, 0, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 1, 0, 0);
        settle();
        chk("reset_state", alert_state, 0);
        chk("reset_event_valid", event_valid, 0);

        // Three samples above CAUTION then a drop: no escalation; four in a row: CAUTION.
        repeat (3) cycle(0, 1, 8'd70, 0, 1, 0, 1);
        cycle(0, 1, 8'd0, 0, 1, 0, 1);
        settle();
        chk("persist_short", alert_state, 0);
        repeat (4) cycle(0, 1, 8'd70, 0, 1, 0, 1);
        settle();
        chk("persist_full", alert_state, 1);
        chk("persist_code", event_code, 4'b0001);

        // Critical bypass, then ack inside and after the hold window.
        cycle(1, 0, 0, 0, 1, 0, 0);
        cycle(0, 1, 8'd0, 16'h8000, 1, 0, 0);
        settle();
        chk("bypass_state", alert_state, 3);
        chk("bypass_lcrit", latched_crit, 4'b1000);
        chk("bypass_alarm", alarm, 1);
        chk("bypass_code", event_code, 4'b0011);
        repeat (4) cycle(0, 1, 8'd0, 0, 1, 0, 1);
        cycle(0, 1, 8'd0, 0, 1, 1, 1);
        settle();
        chk("hold_ack_state", alert_state, 3);
        chk("hold_ack_alarm", alarm, 0);
        repeat (15) cycle(0, 1, 8'd0, 0, 1, 0, 1);
        cycle(0, 1, 8'd0, 0, 1, 1, 1);
        settle();
        chk("deesc_state", alert_state, 0);
        chk("deesc_lcrit", latched_crit, 0);
        chk("deesc_code", event_code, 4'b1100);
        chk("deesc_valid", event_valid, 1);

        // Overwrite of an unaccepted event.
        cycle(1, 0, 0, 0, 1, 0, 0);
        repeat (4) cycle(0, 1, 8'd70, 0, 1, 0, 0);
        repeat (4) cycle(0, 1, 8'd130, 0, 1, 0, 0);
        settle();
        chk("ovf_state", alert_state, 2);
        chk("ovf_code", event_code, 4'b0110);
        chk("ovf_flag", event_overflow, 1);
        cycle(0, 1, 8'd0, 0, 1, 0, 1);
        settle();
        chk("accept_valid", event_valid, 0);

        // Ack coinciding with a bypass is ignored.
        cycle(0, 1, 8'd0, 16'h4000, 1, 1, 0);
        settle();
        chk("ack_bypass_state", alert_state, 3);
        chk("ack_bypass_alarm", alarm, 1);
        chk("ack_bypass_lcrit", latched_crit, 4'b0100);

        // Reset with an event pending.
        cycle(1, 1, 8'd0, 0, 1, 0, 0);
        settle();
        chk("rst_state", alert_state, 0);
        chk("rst_event_valid", event_valid, 0);
        chk("rst_overflow", event_overflow, 0);
        chk("rst_lcrit", latched_crit, 0);

        // Random traffic
        base = 8'd0;
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] fl;
            if ($urandom_range(0, 31) == 0) base = 8'($urandom_range(0, 255));
            fl[15:12] = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            fl[11:0]  = ($urandom_range(0, 3) == 0) ? 12'(1 << $urandom_range(0, 11)) : 12'h0;
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, base, fl,
                  $urandom_range(0, 29) != 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 2) != 0);
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) settle();
        chk("scoreboard_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
